// File: rtl/seq_sdiv.sv
// Iterative radix-2 restoring signed divider: 2*BWIDTH / BWIDTH.
// Define SDIV_REM_EN to compute and output the signed remainder.
module seq_sdiv #(
  parameter int BWIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*BWIDTH-1:0]   dividend,
  input  logic [BWIDTH-1:0]     divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*BWIDTH-1:0]   quotient,
  output logic [BWIDTH-1:0]     remainder,
  output logic                  div0,
  output logic                  ovf
);

  localparam int DW = 2 * BWIDTH;
  localparam int CW = $clog2(DW) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t            state, nstate;
  logic [CW-1:0]     cnt;
  logic [DW-1:0]     dq;
  logic [BWIDTH-1:0] dsr;
  logic [BWIDTH-1:0] prem;
  logic              sdd, sds;
  logic              accept;
  logic              qbit;
  logic              zdiv;
  logic [BWIDTH:0]   shl, trial;
  logic [DW-1:0]     dd_mag, qfix;
  logic [BWIDTH-1:0] ds_mag;

  always_comb begin
    in_ready  = (state == IDLE) & ~rst;
    out_valid = (state == DONE);
    accept    = in_valid & in_ready;
    zdiv      = (divisor == '0);
    dd_mag    = dividend[DW-1] ? -dividend : dividend;
    ds_mag    = divisor[BWIDTH-1] ? -divisor : divisor;
    // shifted partial remainder is BWIDTH+1 bits; trial sign picks the bit
    shl       = {prem, dq[DW-1]};
    trial     = shl - {1'b0, dsr};
    qbit      = ~trial[BWIDTH];
    qfix      = (sdd ^ sds) ? -dq : dq;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (accept) nstate = zdiv ? DONE : CALC;
      CALC: if (cnt == CW'(1)) nstate = FIX;
      FIX:  nstate = DONE;
      DONE: if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dq       <= '0;
      dsr      <= '0;
      prem     <= '0;
      sdd      <= 1'b0;
      sds      <= 1'b0;
      quotient <= '0;
      div0     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state <= nstate;
      unique case (state)
        IDLE: if (accept) begin
          dq   <= dd_mag;
          dsr  <= ds_mag;
          prem <= '0;
          sdd  <= dividend[DW-1];
          sds  <= divisor[BWIDTH-1];
          cnt  <= CW'(DW);
          if (zdiv) begin
            quotient <= '1;
            div0     <= 1'b1;
            ovf      <= 1'b0;
          end
        end
        CALC: begin
          prem <= qbit ? trial[BWIDTH-1:0] : shl[BWIDTH-1:0];
          dq   <= {dq[DW-2:0], qbit};
          cnt  <= cnt - CW'(1);
        end
        FIX: begin
          quotient <= qfix;
          div0     <= 1'b0;
          // only -2^(DW-1) / -1 yields a positive magnitude with MSB set
          ovf      <= ~(sdd ^ sds) & dq[DW-1];
        end
        default: ;
      endcase
    end
  end

`ifdef SDIV_REM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      remainder <= '0;
    end else if (state == IDLE && accept && zdiv) begin
      remainder <= dividend[BWIDTH-1:0];
    end else if (state == FIX) begin
      remainder <= sdd ? -prem : prem;
    end
  end
`else
  assign remainder = '0;
`endif

endmodule

// File: tb/tb_seq_sdiv.sv
// Directed scoreboard bench for seq_sdiv at BWIDTH=8.
// Expected remainder follows SDIV_REM_EN.
module tb_seq_sdiv;

  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   dividend = '0;
  logic [7:0]    divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   quotient;
  logic [7:0]    remainder;
  logic          div0;
  logic          ovf;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        d0;
    logic        ov;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  seq_sdiv #(.BWIDTH(BW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div0(div0), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(logic [15:0] a, logic [7:0] b);
    exp_t e;
    logic signed [15:0] sa, sbv, qq, rr;
    sa = a;
    sbv = {{8{b[7]}}, b};
    e.d0 = 1'b0;
    e.ov = 1'b0;
    e.lat = 18;
    if (b == 8'h00) begin
      e.q = 16'hffff;
      e.r = a[7:0];
      e.d0 = 1'b1;
      e.lat = 1;
    end else if (a == 16'h8000 && b == 8'hff) begin
      e.q = 16'h8000;
      e.r = 8'h00;
      e.ov = 1'b1;
    end else begin
      qq = sa / sbv;
      rr = sa % sbv;
      e.q = qq;
      e.r = rr[7:0];
    end
`ifndef SDIV_REM_EN
    e.r = 8'h00;
`endif
    return e;
  endfunction

  task automatic op(logic [15:0] a, logic [7:0] b, int hold, bit poke);
    int w;
    int lat;
    exp_t e;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_idle", {31'b0, in_ready}, 1);
    dividend = a;
    divisor = b;
    in_valid = 1'b1;
    sbq.push_back(model(a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'h1234;
    divisor = 8'h03;
    lat = 1;
    while (lat < 100) begin
      @(negedge clk);
      if (out_valid) break;
      if (poke && lat == 3) begin
        in_valid = 1'b1;
        dividend = 16'h7777;
        divisor = 8'h02;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat++;
    end
    if (sbq.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
      return;
    end
    e = sbq.pop_front();
    check("latency", lat, e.lat);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", {31'b0, out_valid}, 1);
      check("hold_ready", {31'b0, in_ready}, 0);
      check("hold_q", {16'b0, quotient}, {16'b0, e.q});
      check("hold_r", {24'b0, remainder}, {24'b0, e.r});
      @(negedge clk);
    end
    check("quotient", {16'b0, quotient}, {16'b0, e.q});
    check("remainder", {24'b0, remainder}, {24'b0, e.r});
    check("div0", {31'b0, div0}, {31'b0, e.d0});
    check("ovf", {31'b0, ovf}, {31'b0, e.ov});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("valid_drop", {31'b0, out_valid}, 0);
    check("ready_back", {31'b0, in_ready}, 1);
  endtask

  initial begin
    int seen;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", {31'b0, out_valid}, 0);
    check("rst_q", {16'b0, quotient}, 0);
    check("rst_r", {24'b0, remainder}, 0);
    check("rst_div0", {31'b0, div0}, 0);
    check("rst_ovf", {31'b0, ovf}, 0);
    check("rst_ready", {31'b0, in_ready}, 1);

    op(16'd1000, 8'd7, 0, 1'b0);
    op(-16'sd1000, 8'd7, 0, 1'b0);
    op(16'd1000, -8'sd7, 0, 1'b0);
    op(-16'sd1000, -8'sd7, 0, 1'b0);
    op(16'd5, 8'd0, 0, 1'b0);
    op(16'h8000, 8'hff, 0, 1'b0);
    op(16'd1000, 8'h80, 0, 1'b0);
    op(16'h7fff, 8'd1, 0, 1'b0);
    op(16'd3, 8'd9, 0, 1'b0);
    op(16'd1000, 8'd7, 10, 1'b0);
    op(16'd1234, 8'd11, 0, 1'b1);

    // abort mid-CALC; prior result (1234/11) is still on the outputs
    @(negedge clk);
    dividend = 16'd1000;
    divisor = 8'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready_low", {31'b0, in_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_valid", {31'b0, out_valid}, 0);
    check("abort_q", {16'b0, quotient}, 0);
    check("abort_r", {24'b0, remainder}, 0);
    check("abort_div0", {31'b0, div0}, 0);
    check("abort_ovf", {31'b0, ovf}, 0);
    check("abort_ready", {31'b0, in_ready}, 1);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_result", seen, 0);

    op(16'd1000, 8'd7, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/seq_sdiv.md
Name: seq_sdiv

Overview:
- Iterative signed divider; the inverse of the wide signed multiplier used in the HMM-Viterbi datapath.
- Divides a 2*BWIDTH-bit signed dividend by a BWIDTH-bit signed divisor, producing a quotient and a remainder.
- Radix-2 restoring algorithm on magnitudes, with sign fix-up at the end; one division in flight at a time.
- Valid/ready handshake on both input and output, so it drops into the score-normalisation path without extra glue.

Parameters:
- BWIDTH, 64, divisor/remainder width; dividend and quotient are 2*BWIDTH.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  dividend/divisor valid.
- in_ready  out  1  block can accept an operation (high only in IDLE).
- dividend  in  2*BWIDTH  signed dividend.
- divisor  in  BWIDTH  signed divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  2*BWIDTH  signed quotient, truncated toward zero.
- remainder  out  BWIDTH  signed remainder; sign follows dividend.
- div0  out  1  divisor was zero.
- ovf  out  1  quotient overflowed (only -2^(2*BWIDTH-1) / -1).

Behaviour:
- Reset values: in_ready=0 during the rst cycle, then 1. out_valid=0, quotient=0, remainder=0, div0=0, ovf=0. State=IDLE, iteration counter=0.
- States are IDLE, CALC, FIX and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch |dividend| and |divisor| (unsigned, with 2*BWIDTH-bit and BWIDTH-bit magnitude respectively), plus both sign bits.
  - If divisor==0, go to DONE with quotient=all ones, remainder=dividend[BWIDTH-1:0], div0=1, ovf=0.
  - Otherwise go to CALC with counter=2*BWIDTH.
- CALC, one quotient bit per cycle, MSB first:
  - Partial remainder is BWIDTH+1 bits. Shift in the next dividend bit.
  - Trial-subtract |divisor|; if the result is non-negative, keep it and set the quotient bit to 1, else restore.
  - Decrement counter; when it reaches 1 on this cycle, go to FIX.
  - Exactly 2*BWIDTH CALC cycles.
- FIX, one cycle:
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder is negated if the dividend is negative.
  - Register the outputs and go to DONE.
  - ovf=1 iff dividend==-2^(2*BWIDTH-1) and divisor==-1; the quotient then wraps to -2^(2*BWIDTH-1), remainder=0.
- DONE:
  - out_valid=1; outputs held stable while out_ready=0.
  - On out_ready, drop out_valid and return to IDLE; in_ready=1 the next cycle (no same-cycle accept).
- Latency, measured from the accept edge to out_valid high:
  - Normal division: 2*BWIDTH+2 cycles.
  - Divide-by-zero: 1 cycle.
- Back-to-back throughput is one operation per 2*BWIDTH+3 cycles when out_ready is tied high.
- in_valid while busy is ignored; input values are sampled only on the accept edge.
- rst asserted in any state, including mid-CALC: abort and return to reset values next cycle; no result is emitted.
- Outputs change only on the FIX→DONE and DONE→IDLE transitions, and on the IDLE→DONE divide-by-zero path.

Optional Feature:
- Macro: SDIV_REM_EN.
- Defined: the remainder is computed, sign-corrected and output as above.
- Undefined:
  - remainder port is tied to 0 and the remainder registers and their negation logic are removed.
  - The divide-by-zero remainder is also 0.
  - Quotient, flags, latency and handshake are unchanged.

Test Plan (BWIDTH=8, SDIV_REM_EN defined unless noted):
- dividend=1000, divisor=7 → quotient=142, remainder=6, div0=0, ovf=0; out_valid exactly 18 cycles after accept.
- dividend=-1000, divisor=7 → quotient=-142, remainder=-6. dividend=1000, divisor=-7 → quotient=-142, remainder=6.
- dividend=5, divisor=0 → quotient=16'hFFFF, remainder=8'h05, div0=1; out_valid 1 cycle after accept.
- dividend=16'h8000, divisor=-1 → quotient=16'h8000, remainder=0, ovf=1.
- Backpressure and busy:
  - Hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0.
  - Pulse in_valid during CALC → ignored, and the first result is unaffected.
- Reset and macro off:
  - Assert rst at CALC cycle 5 → all outputs return to reset values, in_ready=1 the following cycle, no out_valid.
  - Rerun 1000/7 with SDIV_REM_EN undefined → quotient=142, remainder=0.
